sample_frame_buffer: RTL and testbench

Upstream stage of fft_256. It accepts a stream of signed audio samples and assembles them into 256-sample frames in a ping-pong pair of register banks. Each completed frame is presented on the parallel time_samples bus and launched with a one-cycle fft_start pulse. Capture into the other bank continues while the FFT runs. If the FFT is still busy when a frame completes, that frame is dropped and flagged.

---
 rtl/audio_pkg.sv | 14 +
 rtl/frame_bank.sv | 26 ++
 rtl/sample_frame_buffer.sv | 102 ++++++++++
 tb/tb_sample_frame_buffer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio types for the sample frame buffer and fft_256.
package audio_pkg;

  localparam int WIDTH = 12;
  localparam int N     = 256;

  typedef logic signed [WIDTH-1:0] sample_t;
  typedef sample_t [0:N-1]         frame_t;
  typedef logic [$clog2(N)-1:0]    idx_t;

  // Write index of the final sample of a frame.
  localparam idx_t LAST_IDX = idx_t'(N - 1);

endpackage

// File: rtl/frame_bank.sv
// One N-entry sample bank: synchronous clear, single-entry write, full-frame read.
module frame_bank
  import audio_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_clr,
  input  logic    i_we,
  input  idx_t    i_idx,
  input  sample_t i_data,
  output frame_t  o_frame
);

  frame_t r_mem;

  // Clear the whole bank, or store one sample at the write index.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_mem <= '0;
    end else if (i_we) begin
      r_mem[i_idx] <= i_data;
    end
  end

  assign o_frame = r_mem;

endmodule

// File: rtl/sample_frame_buffer.sv
// Ping-pong frame assembler feeding fft_256: captures samples into one bank
// while the other bank is presented to the FFT.
module sample_frame_buffer
  import audio_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst,
  input  sample_t i_sample_in,
  input  logic    i_sample_valid,
  input  logic    i_fft_done,
  output logic    o_fft_start,
  output frame_t  o_time_samples,
  output logic    o_busy,
  output logic    o_overrun
);

  idx_t   r_wr_idx;
  logic   r_wr_bank;
  logic   r_rd_bank;
  logic   r_busy;
  logic   r_fft_start;
  logic   r_overrun;

  logic   w_complete;
  logic   w_done_live;
  logic   w_free;
  logic   w_we0;
  logic   w_we1;
  frame_t w_frame0;
  frame_t w_frame1;

  // fft_done seen in the start cycle belongs to the previous frame, so it is ignored.
  assign w_done_live = i_fft_done && !r_fft_start;
  assign w_complete  = i_sample_valid && (r_wr_idx == LAST_IDX);
  assign w_free      = !r_busy || w_done_live;
  assign w_we0       = i_sample_valid && (r_wr_bank == 1'b0);
  assign w_we1       = i_sample_valid && (r_wr_bank == 1'b1);

  frame_bank u_bank0 (
    .i_clk   (i_clk),
    .i_clr   (i_rst),
    .i_we    (w_we0),
    .i_idx   (r_wr_idx),
    .i_data  (i_sample_in),
    .o_frame (w_frame0)
  );

  frame_bank u_bank1 (
    .i_clk   (i_clk),
    .i_clr   (i_rst),
    .i_we    (w_we1),
    .i_idx   (r_wr_idx),
    .i_data  (i_sample_in),
    .o_frame (w_frame1)
  );

  // Write pointer, bank selects, FFT handshake and sticky overrun flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_idx    <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b1;
      r_busy      <= 1'b0;
      r_fft_start <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_fft_start <= 1'b0;
      if (i_sample_valid) begin
        r_wr_idx <= r_wr_idx + idx_t'(1);
      end
      if (w_done_live) begin
        r_busy <= 1'b0;
      end
      if (w_complete) begin
        if (w_free) begin
          // Hand the finished bank to the FFT and capture into the other one.
          r_rd_bank   <= r_wr_bank;
          r_wr_bank   <= ~r_wr_bank;
          r_fft_start <= 1'b1;
          r_busy      <= 1'b1;
        end else begin
          // Drop: keep writing the same bank so the next frame overwrites it.
          r_overrun <= 1'b1;
        end
      end
    end
  end

  // The displayed bank never changes while busy, so the FFT sees a stable frame.
  always_comb begin
    if (r_rd_bank) begin
      o_time_samples = w_frame1;
    end else begin
      o_time_samples = w_frame0;
    end
  end

  assign o_fft_start = r_fft_start;
  assign o_busy      = r_busy;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_sample_frame_buffer.sv
// Self-checking bench for sample_frame_buffer: scenario table, reset
// sequences and a randomized run against a frame-level reference model.
module tb_sample_frame_buffer;
  import audio_pkg::*;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  logic    valid = 1'b0;
  logic    done = 1'b0;
  sample_t sin = '0;
  logic    start;
  logic    busy;
  logic    ovr;
  frame_t  ts;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sample_frame_buffer dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_sample_in    (sin),
    .i_sample_valid (valid),
    .i_fft_done     (done),
    .o_fft_start    (start),
    .o_time_samples (ts),
    .o_busy         (busy),
    .o_overrun      (ovr)
  );

  // Reference model: the partial frame is a queue, the presented frame an array.
  sample_t m_q[$];
  sample_t m_disp[N];
  bit      m_busy;
  bit      m_start;
  bit      m_ovr;

  typedef struct {
    string name;
    int    base;
    int    mult;
    bit    s0_en;
    int    s0;
    int    gap;
    bit    pre_done;
    bit    done_last;
    bit    exp_start;
    bit    exp_busy;
    bit    exp_ovr;
    int    eb;
    int    em;
    bit    es0_en;
    int    es0;
  } scen_t;

  scen_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_frame(input string name, input sample_t exp[N]);
    int bad;
    bad = -1;
    for (int k = 0; k < N; k++) begin
      if (bad < 0 && ts[k] !== exp[k]) bad = k;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: time_samples[%0d] got %0h expected %0h", name, bad, ts[bad], exp[bad]);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input sample_t s, input bit d);
    bit free;
    bit nstart;
    if (r) begin
      m_q.delete();
      for (int k = 0; k < N; k++) m_disp[k] = '0;
      m_busy  = 1'b0;
      m_start = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      free   = !m_busy || (d && !m_start);
      nstart = 1'b0;
      if (d && !m_start) m_busy = 1'b0;
      if (v) m_q.push_back(s);
      if (m_q.size() == N) begin
        if (free) begin
          for (int k = 0; k < N; k++) m_disp[k] = m_q[k];
          nstart = 1'b1;
          m_busy = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
        m_q.delete();
      end
      m_start = nstart;
    end
  endtask

  // One clock: drive inputs, advance the model, sample the DUT 1 unit after the edge.
  task automatic step(input bit r, input bit v, input sample_t s, input bit d);
    rst   = r;
    valid = v;
    sin   = s;
    done  = d;
    @(posedge clk);
    model_step(r, v, s, d);
    #1;
    chk("model_start", {31'd0, start}, {31'd0, m_start});
    chk("model_busy", {31'd0, busy}, {31'd0, m_busy});
    chk("model_overrun", {31'd0, ovr}, {31'd0, m_ovr});
    chk_frame("model_frame", m_disp);
  endtask

  task automatic send_frame(input int base, input int mult, input bit s0_en, input int s0,
                            input int gap, input bit done_last);
    sample_t v;
    for (int k = 0; k < N; k++) begin
      v = (k == 0 && s0_en) ? sample_t'(s0) : sample_t'(base + mult * k);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, '0, 1'b0);
      step(1'b0, 1'b1, v, done_last && (k == N - 1));
    end
  endtask

  task automatic check_reset_state(input string name);
    sample_t zf[N];
    for (int k = 0; k < N; k++) zf[k] = '0;
    chk({name, "_start"}, {31'd0, start}, 32'd0);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_overrun"}, {31'd0, ovr}, 32'd0);
    chk_frame({name, "_frame"}, zf);
  endtask

  task automatic check_const_frame(input string name, input int val);
    sample_t ef[N];
    for (int k = 0; k < N; k++) ef[k] = sample_t'(val);
    chk_frame(name, ef);
  endtask

  initial begin
    sample_t          ef[N];
    logic [WIDTH-1:0] bits;

    //            name      base  mult s0en s0   gap pre  dlast  st bsy ovr  eb   em es0en es0
    tbl[0] = '{"basic",     0,    1,   0,   0,    0,  0,   0,    1, 1,  0,   0,   1, 0,   0};
    tbl[1] = '{"neg0",      0,    1,   1,   -163, 0,  1,   0,    1, 1,  0,   0,   1, 1,   -163};
    tbl[2] = '{"gapped",    0,    1,   0,   0,    2,  1,   0,    1, 1,  0,   0,   1, 0,   0};
    tbl[3] = '{"simul",     0,    2,   0,   0,    0,  0,   1,    1, 1,  0,   0,   2, 0,   0};
    tbl[4] = '{"overrun",   1000, 1,   0,   0,    0,  0,   0,    0, 1,  1,   0,   2, 0,   0};
    tbl[5] = '{"recover",   0,    -1,  0,   0,    0,  1,   0,    1, 1,  1,   0,   -1, 0,  0};

    // Reset held for two cycles, then released.
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    check_reset_state("reset");

    // Scenario table.
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].pre_done) step(1'b0, 1'b0, '0, 1'b1);
      send_frame(tbl[i].base, tbl[i].mult, tbl[i].s0_en, tbl[i].s0, tbl[i].gap, tbl[i].done_last);
      for (int k = 0; k < N; k++)
        ef[k] = (k == 0 && tbl[i].es0_en) ? sample_t'(tbl[i].es0) : sample_t'(tbl[i].eb + tbl[i].em * k);
      chk({tbl[i].name, "_start"}, {31'd0, start}, {31'd0, tbl[i].exp_start});
      chk({tbl[i].name, "_busy"}, {31'd0, busy}, {31'd0, tbl[i].exp_busy});
      chk({tbl[i].name, "_overrun"}, {31'd0, ovr}, {31'd0, tbl[i].exp_ovr});
      chk_frame({tbl[i].name, "_frame"}, ef);
      if (i == 1) begin
        bits = ts[0];
        chk("neg0_bits", {20'd0, bits}, 32'h0000_0F5D);
      end
      step(1'b0, 1'b0, '0, 1'b0);
      chk({tbl[i].name, "_start_one_cycle"}, {31'd0, start}, 32'd0);
    end

    // Reset in the middle of a frame discards the partial capture.
    for (int k = 0; k < 100; k++) step(1'b0, 1'b1, sample_t'(50 + k), 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    check_reset_state("rst_midframe");
    send_frame(7, 0, 1'b0, 0, 0, 1'b0);
    chk("rst_midframe_start", {31'd0, start}, 32'd1);
    check_const_frame("rst_midframe_frame", 7);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("rst_midframe_single_start", {31'd0, start}, 32'd0);

    // Reset while busy abandons the frame; a later fft_done has no effect.
    chk("rst_busy_pre", {31'd0, busy}, 32'd1);
    step(1'b1, 1'b0, '0, 1'b0);
    check_reset_state("rst_busy");
    step(1'b0, 1'b0, '0, 1'b1);
    chk("rst_busy_done_ignored", {31'd0, busy}, 32'd0);
    send_frame(7, 0, 1'b0, 0, 0, 1'b0);
    chk("rst_busy_start", {31'd0, start}, 32'd1);
    chk("rst_busy_overrun", {31'd0, ovr}, 32'd0);
    check_const_frame("rst_busy_frame", 7);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 6000; c++) begin
      step(($urandom_range(0, 1999) == 0), ($urandom_range(0, 9) < 8),
           sample_t'($urandom), ($urandom_range(0, 199) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
